alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates between them, registers operands, drives the ALU for one cycle, registers the result and flags, and returns them to the winning requester. It sits between the pipeline control and the ALU instance in the core top level.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/rr_arb2.sv | 44 ++++
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, arbiter states and op legality helper
//
// Purpose: common definitions imported by the ALU arbiter and its testbench.
// Ports: none (package).
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal_op = 1'b1;
      default:                                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU-side bundle of the ALU arbiter
//
// Purpose: groups both requester channels and the ALU connection.
// Modports:
//   slave  - the arbiter: takes req*_valid/op/x/y, rsp*_ready, alu_s/zr/ng;
//            drives req*_ready, rsp*_valid/result/zr/ng/err, alu_op/x/y.
//   master - the environment (requesters plus ALU), the mirror image.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  req0_valid, req0_ready;
  logic [OP_WIDTH-1:0]   req0_op;
  logic [DATA_WIDTH-1:0] req0_x, req0_y;
  logic                  rsp0_valid, rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_result;
  logic                  rsp0_zr, rsp0_ng, rsp0_err;

  logic                  req1_valid, req1_ready;
  logic [OP_WIDTH-1:0]   req1_op;
  logic [DATA_WIDTH-1:0] req1_x, req1_y;
  logic                  rsp1_valid, rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_result;
  logic                  rsp1_zr, rsp1_ng, rsp1_err;

  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_x, alu_y, alu_s;
  logic                  alu_zr, alu_ng;

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y, rsp0_ready,
    input  req1_valid, req1_op, req1_x, req1_y, rsp1_ready,
    input  alu_s, alu_zr, alu_ng,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zr, rsp0_ng, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zr, rsp1_ng, rsp1_err,
    output alu_op, alu_x, alu_y
  );

  modport master (
    output req0_valid, req0_op, req0_x, req0_y, rsp0_ready,
    output req1_valid, req1_op, req1_x, req1_y, rsp1_ready,
    output alu_s, alu_zr, alu_ng,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zr, rsp0_ng, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zr, rsp1_ng, rsp1_err,
    input  alu_op, alu_x, alu_y
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational grant with registered last-grant pointer
//
// Purpose: picks one of two requesters; ties go to port 0 when PRIO_FIXED=1,
// otherwise to the port not granted last time.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req_i[1:0]  - request vector (bit n = port n)
//   accept_i    - a grant was taken this cycle; advances the pointer
//   grant_o[1:0]- one-hot grant (all zero when nobody requests)
module rr_arb2 #(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // 1 = port 1 was granted most recently, so port 0 wins the next tie.
  // Reset to 1 so that the first tie after reset goes to port 0.
  logic last1_q, last1_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ((PRIO_FIXED != 0) || last1_q) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last1_d = last1_q;
    if (accept_i) last1_d = grant_o[1];
  end

  always_ff @(posedge clk) begin
    if (reset) last1_q <= 1'b1;
    else       last1_q <= last1_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between execute and address/branch ports
//
// Purpose: arbitrates two valid/ready requesters, registers the winner's
// operands onto the ALU for one cycle, registers result/flags and returns
// them on the owner's response channel. IDLE -> ISSUE -> RESP -> IDLE.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - alu_arbiter_if.slave: req0/rsp0 (execute), req1/rsp1
//                (address/branch), alu_op/x/y out, alu_s/zr/ng in
// Optional build macro: ALU_ARB_OP_CHECK_EN - illegal ops bypass the ALU and
// answer after one edge with result 0 and err=1; otherwise err is always 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int PRIO_FIXED = 0
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

`ifdef ALU_ARB_OP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [DATA_WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic                  zr0_q, zr0_d, ng0_q, ng0_d, err0_q, err0_d;
  logic                  zr1_q, zr1_d, ng1_q, ng1_d, err1_q, err1_d;

  logic [1:0]            grant;
  logic                  in_idle, accept, rsp_fire, op_legal, op_hi_zero;
  logic [OP_WIDTH-1:0]   sel_op;
  logic [DATA_WIDTH-1:0] sel_x, sel_y;

  rr_arb2 #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({bus.req1_valid, bus.req0_valid}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign in_idle        = (state_q == ST_IDLE);
  assign bus.req0_ready = in_idle & grant[0];
  assign bus.req1_ready = in_idle & grant[1];
  assign accept = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

  assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;
  assign sel_x  = grant[1] ? bus.req1_x  : bus.req0_x;
  assign sel_y  = grant[1] ? bus.req1_y  : bus.req0_y;

  // Op codes wider than a nibble are legal only with zero upper bits.
  if (OP_WIDTH > 4) begin : g_op_hi
    assign op_hi_zero = ~|sel_op[OP_WIDTH-1:4];
  end else begin : g_op_nohi
    assign op_hi_zero = 1'b1;
  end

  // Without the check feature every op counts as legal, so the bypass path
  // and the err registers stay constant zero.
  assign op_legal = ~CHECK_EN | (is_legal_op(sel_op[3:0]) & op_hi_zero);

  assign rsp_fire = (state_q == ST_RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    res0_d  = res0_q;
    zr0_d   = zr0_q;
    ng0_d   = ng0_q;
    err0_d  = err0_q;
    res1_d  = res1_q;
    zr1_d   = zr1_q;
    ng1_d   = ng1_q;
    err1_d  = err1_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          if (op_legal) begin
            op_d    = sel_op;
            x_d     = sel_x;
            y_d     = sel_y;
            state_d = ST_ISSUE;
          end else begin
            // Illegal op: ALU operands untouched, answer straight away.
            if (grant[1]) begin
              res1_d = '0; zr1_d = 1'b0; ng1_d = 1'b0; err1_d = 1'b1;
            end else begin
              res0_d = '0; zr0_d = 1'b0; ng0_d = 1'b0; err0_d = 1'b1;
            end
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (owner_q) begin
          res1_d = bus.alu_s; zr1_d = bus.alu_zr; ng1_d = bus.alu_ng; err1_d = 1'b0;
        end else begin
          res0_d = bus.alu_s; zr0_d = bus.alu_zr; ng0_d = bus.alu_ng; err0_d = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // No acceptance in the handoff cycle: ready is only raised in IDLE.
        if (rsp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res0_q  <= '0;
      zr0_q   <= 1'b0;
      ng0_q   <= 1'b0;
      err0_q  <= 1'b0;
      res1_q  <= '0;
      zr1_q   <= 1'b0;
      ng1_q   <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res0_q  <= res0_d;
      zr0_q   <= zr0_d;
      ng0_q   <= ng0_d;
      err0_q  <= err0_d;
      res1_q  <= res1_d;
      zr1_q   <= zr1_d;
      ng1_q   <= ng1_d;
      err1_q  <= err1_d;
    end
  end

  assign bus.alu_op      = op_q;
  assign bus.alu_x       = x_q;
  assign bus.alu_y       = y_q;

  assign bus.rsp0_valid  = (state_q == ST_RESP) & ~owner_q;
  assign bus.rsp1_valid  = (state_q == ST_RESP) &  owner_q;
  assign bus.rsp0_result = res0_q;
  assign bus.rsp0_zr     = zr0_q;
  assign bus.rsp0_ng     = ng0_q;
  assign bus.rsp0_err    = err0_q & CHECK_EN;
  assign bus.rsp1_result = res1_q;
  assign bus.rsp1_zr     = zr1_q;
  assign bus.rsp1_ng     = ng1_q;
  assign bus.rsp1_err    = err1_q & CHECK_EN;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter (round-robin and fixed-priority)
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) ia ();
  alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) ib ();

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .PRIO_FIXED(0)) dut_rr (
    .clk(clk), .reset(reset), .bus(ia));
  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .PRIO_FIXED(1)) dut_fx (
    .clk(clk), .reset(reset), .bus(ib));

  // Stand-in for the external combinational ALU; unknown codes give x^y.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'b0000: alu_f = x & y;
      4'b0001: alu_f = x | y;
      4'b0010: alu_f = x + y;
      4'b0110: alu_f = x - y;
      4'b0111: alu_f = {31'b0, ($signed(x) < $signed(y))};
      4'b1100: alu_f = ~(x | y);
      default: alu_f = x ^ y;
    endcase
  endfunction

  assign ia.alu_s  = alu_f(ia.alu_op, ia.alu_x, ia.alu_y);
  assign ia.alu_zr = (ia.alu_s == 32'd0);
  assign ia.alu_ng = ia.alu_s[31];
  assign ib.alu_s  = alu_f(ib.alu_op, ib.alu_x, ib.alu_y);
  assign ib.alu_zr = (ib.alu_s == 32'd0);
  assign ib.alu_ng = ib.alu_s[31];

  typedef struct {
    logic v0; logic [3:0] op0; logic [31:0] x0; logic [31:0] y0;
    logic v1; logic [3:0] op1; logic [31:0] x1; logic [31:0] y1;
    int port; logic [31:0] res; logic zr; logic ng; logic err; int lat; logic [3:0] aop;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ia.req0_valid = 0; ia.req0_op = 0; ia.req0_x = 0; ia.req0_y = 0; ia.rsp0_ready = 0;
    ia.req1_valid = 0; ia.req1_op = 0; ia.req1_x = 0; ia.req1_y = 0; ia.rsp1_ready = 0;
    ib.req0_valid = 0; ib.req0_op = 0; ib.req0_x = 0; ib.req0_y = 0; ib.rsp0_ready = 0;
    ib.req1_valid = 0; ib.req1_op = 0; ib.req1_x = 0; ib.req1_y = 0; ib.rsp1_ready = 0;
  endtask

  // port: 0/1 granted, 2 both ready (illegal), -1 timeout
  task automatic a_wait_grant(output int port);
    port = -1;
    for (int c = 0; c < 20; c++) begin
      if (ia.req0_ready || ia.req1_ready) begin
        port = (ia.req0_ready && ia.req1_ready) ? 2 : (ia.req1_ready ? 1 : 0);
        return;
      end
      tick();
    end
  endtask

  task automatic b_wait_grant(output int port);
    port = -1;
    for (int c = 0; c < 20; c++) begin
      if (ib.req0_ready || ib.req1_ready) begin
        port = (ib.req0_ready && ib.req1_ready) ? 2 : (ib.req1_ready ? 1 : 0);
        return;
      end
      tick();
    end
  endtask

  // Called at the sample point where ready was seen; lat = edges until a response shows.
  task automatic a_wait_rsp(output int lat);
    lat = 99;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ia.rsp0_valid || ia.rsp1_valid) begin
        lat = c + 1;
        return;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req0_ready"}, 64'(ia.req0_ready), 64'(0));
    chk({tag, "_req1_ready"}, 64'(ia.req1_ready), 64'(0));
    chk({tag, "_rsp0_valid"}, 64'(ia.rsp0_valid), 64'(0));
    chk({tag, "_rsp1_valid"}, 64'(ia.rsp1_valid), 64'(0));
    chk({tag, "_rsp0_res"},   64'(ia.rsp0_result), 64'(0));
    chk({tag, "_rsp1_res"},   64'(ia.rsp1_result), 64'(0));
    chk({tag, "_rsp0_flags"}, 64'({ia.rsp0_zr, ia.rsp0_ng, ia.rsp0_err}), 64'(0));
    chk({tag, "_rsp1_flags"}, 64'({ia.rsp1_zr, ia.rsp1_ng, ia.rsp1_err}), 64'(0));
    chk({tag, "_alu_op"},     64'(ia.alu_op), 64'(0));
    chk({tag, "_alu_x"},      64'(ia.alu_x), 64'(0));
    chk({tag, "_alu_y"},      64'(ia.alu_y), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int port, lat;
    logic [31:0] res;

    //            v0   op0    x0            y0            v1   op1    x1            y1            port res           zr   ng   err  lat aop
    tbl[0] = '{1'b1, 4'h2, 32'd5,        32'd7,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'd12,        1'b0, 1'b0, 1'b0, 2, 4'h2};
    tbl[1] = '{1'b0, 4'h0, 32'd0,        32'd0,        1'b1, 4'h0, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'h0F000F00,  1'b0, 1'b0, 1'b0, 2, 4'h0};
    tbl[2] = '{1'b1, 4'h6, 32'd7,        32'd7,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'd0,         1'b1, 1'b0, 1'b0, 2, 4'h6};
    tbl[3] = '{1'b0, 4'h0, 32'd0,        32'd0,        1'b1, 4'h7, 32'hFFFFFFFF, 32'd1,        1, 32'd1,         1'b0, 1'b0, 1'b0, 2, 4'h7};
    tbl[4] = '{1'b1, 4'hC, 32'd0,        32'd0,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b0, 2, 4'hC};
    tbl[5] = '{1'b1, 4'h1, 32'd1,        32'd2,        1'b1, 4'h2, 32'd1,        32'd1,        1, 32'd2,         1'b0, 1'b0, 1'b0, 2, 4'h2};
    tbl[6] = '{1'b1, 4'h1, 32'd1,        32'd2,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'd3,         1'b0, 1'b0, 1'b0, 2, 4'h1};
`ifdef ALU_ARB_OP_CHECK_EN
    tbl[7] = '{1'b1, 4'h3, 32'd6,        32'd3,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'd0,         1'b0, 1'b0, 1'b1, 1, 4'h1};
`else
    tbl[7] = '{1'b1, 4'h3, 32'd6,        32'd3,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'd5,         1'b0, 1'b0, 1'b0, 2, 4'h3};
`endif
    tbl[8] = '{1'b1, 4'h0, 32'hF,        32'h3,        1'b1, 4'h6, 32'd2,        32'd5,        1, 32'hFFFFFFFD,  1'b0, 1'b1, 1'b0, 2, 4'h6};
    tbl[9] = '{1'b1, 4'h0, 32'hF,        32'h3,        1'b0, 4'h0, 32'd0,        32'd0,        0, 32'd3,         1'b0, 1'b0, 1'b0, 2, 4'h0};

    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    check_reset_state("in_reset");
    reset = 1'b0;
    tick();
    check_reset_state("after_reset");
    chk("fx_rsp_valid_reset", 64'({ib.rsp0_valid, ib.rsp1_valid}), 64'(0));

    // Both ports valid continuously: grants alternate 0,1,0,1.
    ia.req0_op = 4'h6; ia.req0_x = 32'd3;    ia.req0_y = 32'd5;
    ia.req1_op = 4'h1; ia.req1_x = 32'hF0;   ia.req1_y = 32'h0F;
    ia.req0_valid = 1; ia.req1_valid = 1; ia.rsp0_ready = 1; ia.rsp1_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      a_wait_grant(port);
      chk($sformatf("rr_grant%0d", i), 64'(port), 64'(i % 2));
      a_wait_rsp(lat);
      chk($sformatf("rr_lat%0d", i), 64'(lat), 64'(2));
      if (i % 2 == 0) begin
        chk($sformatf("rr_res%0d", i), 64'({ia.rsp0_valid, ia.rsp0_ng, ia.rsp0_zr, ia.rsp0_result}),
            64'({1'b1, 1'b1, 1'b0, 32'hFFFFFFFE}));
        chk($sformatf("rr_other%0d", i), 64'(ia.rsp1_valid), 64'(0));
      end else begin
        chk($sformatf("rr_res%0d", i), 64'({ia.rsp1_valid, ia.rsp1_ng, ia.rsp1_zr, ia.rsp1_result}),
            64'({1'b1, 1'b0, 1'b0, 32'h000000FF}));
        chk($sformatf("rr_other%0d", i), 64'(ia.rsp0_valid), 64'(0));
      end
      tick();
    end
    clear_inputs();
    #1;

    // Table: single requests and ties, one transaction each.
    for (int i = 0; i < 10; i++) begin
      ia.req0_valid = tbl[i].v0; ia.req0_op = tbl[i].op0; ia.req0_x = tbl[i].x0; ia.req0_y = tbl[i].y0;
      ia.req1_valid = tbl[i].v1; ia.req1_op = tbl[i].op1; ia.req1_x = tbl[i].x1; ia.req1_y = tbl[i].y1;
      ia.rsp0_ready = 0; ia.rsp1_ready = 0;
      #1;
      a_wait_grant(port);
      chk($sformatf("v%0d_grant", i), 64'(port), 64'(tbl[i].port));
      a_wait_rsp(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      if (tbl[i].port == 1) begin
        chk($sformatf("v%0d_res", i), 64'(ia.rsp1_result), 64'(tbl[i].res));
        chk($sformatf("v%0d_flags", i), 64'({ia.rsp1_zr, ia.rsp1_ng, ia.rsp1_err}),
            64'({tbl[i].zr, tbl[i].ng, tbl[i].err}));
        chk($sformatf("v%0d_valids", i), 64'({ia.rsp1_valid, ia.rsp0_valid}), 64'(2'b10));
        ia.req1_valid = 0; ia.rsp1_ready = 1;
      end else begin
        chk($sformatf("v%0d_res", i), 64'(ia.rsp0_result), 64'(tbl[i].res));
        chk($sformatf("v%0d_flags", i), 64'({ia.rsp0_zr, ia.rsp0_ng, ia.rsp0_err}),
            64'({tbl[i].zr, tbl[i].ng, tbl[i].err}));
        chk($sformatf("v%0d_valids", i), 64'({ia.rsp1_valid, ia.rsp0_valid}), 64'(2'b01));
        ia.req0_valid = 0; ia.rsp0_ready = 1;
      end
      chk($sformatf("v%0d_alu_op", i), 64'(ia.alu_op), 64'(tbl[i].aop));
      tick();
      chk($sformatf("v%0d_rsp_dropped", i), 64'({ia.rsp1_valid, ia.rsp0_valid}), 64'(0));
      ia.rsp0_ready = 0; ia.rsp1_ready = 0;
    end
    clear_inputs();
    #1;

    // Backpressure: port 0 SLT 1<2 held for 5 cycles while port 1 waits.
    ia.req0_op = 4'h7; ia.req0_x = 32'd1; ia.req0_y = 32'd2; ia.req0_valid = 1;
    #1;
    a_wait_grant(port);
    chk("bp_grant", 64'(port), 64'(0));
    a_wait_rsp(lat);
    chk("bp_lat", 64'(lat), 64'(2));
    ia.req0_valid = 0;
    ia.req1_op = 4'h2; ia.req1_x = 32'd4; ia.req1_y = 32'd4; ia.req1_valid = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_hold%0d", c), 64'({ia.rsp0_valid, ia.rsp0_result, ia.req1_ready}),
          64'({1'b1, 32'd1, 1'b0}));
      tick();
    end
    ia.rsp0_ready = 1;
    tick();
    chk("bp_idle_resume", 64'({ia.rsp0_valid, ia.req1_ready}), 64'(2'b01));
    ia.rsp0_ready = 0;
    a_wait_grant(port);
    chk("bp_p1_grant", 64'(port), 64'(1));
    a_wait_rsp(lat);
    chk("bp_p1_res", 64'({ia.rsp1_valid, ia.rsp1_result}), 64'({1'b1, 32'd8}));
    ia.req1_valid = 0; ia.rsp1_ready = 1;
    tick();
    clear_inputs();
    #1;

    // Reset in ISSUE abandons the op; next tie goes to port 0.
    ia.req0_op = 4'h2; ia.req0_x = 32'd5; ia.req0_y = 32'd7; ia.req0_valid = 1;
    #1;
    a_wait_grant(port);
    chk("rst_grant", 64'(port), 64'(0));
    tick();
    ia.req0_valid = 0;
    chk("rst_issue_alu_op", 64'(ia.alu_op), 64'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_reset_state("rst_issue");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_no_rsp%0d", c), 64'({ia.rsp1_valid, ia.rsp0_valid}), 64'(0));
    end
    ia.req0_op = 4'h0; ia.req0_x = 32'd3; ia.req0_y = 32'd5; ia.req0_valid = 1;
    ia.req1_op = 4'h1; ia.req1_x = 32'd3; ia.req1_y = 32'd5; ia.req1_valid = 1;
    #1;
    a_wait_grant(port);
    chk("rst_tie_grant", 64'(port), 64'(0));
    a_wait_rsp(lat);
    res = ia.rsp0_result;
    chk("rst_tie_res", 64'({ia.rsp0_valid, res}), 64'({1'b1, 32'd1}));
    clear_inputs();
    ia.rsp0_ready = 1;
    tick();
    clear_inputs();

    // Fixed-priority instance: port 0 wins every tie until it withdraws.
    ib.req0_op = 4'h2; ib.req0_x = 32'd1;  ib.req0_y = 32'd2;  ib.req0_valid = 1;
    ib.req1_op = 4'h2; ib.req1_x = 32'd10; ib.req1_y = 32'd20; ib.req1_valid = 1;
    ib.rsp0_ready = 1; ib.rsp1_ready = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      b_wait_grant(port);
      chk($sformatf("fx_grant%0d", i), 64'(port), 64'(0));
      tick(); tick();
      chk($sformatf("fx_rsp%0d", i), 64'({ib.rsp0_valid, ib.rsp1_valid, ib.rsp0_result}),
          64'({1'b1, 1'b0, 32'd3}));
      tick();
    end
    ib.req0_valid = 0;
    #1;
    b_wait_grant(port);
    chk("fx_p1_grant", 64'(port), 64'(1));
    tick(); tick();
    chk("fx_p1_rsp", 64'({ib.rsp1_valid, ib.rsp0_valid, ib.rsp1_result}), 64'({1'b1, 1'b0, 32'd30}));
    ib.req1_valid = 0;
    tick();
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
